// File: rtl/neuron_param_dp_ram.sv
// Purpose: parameter RAM with one read port and one write port, self-clearing after reset.
// Latency: reads are registered, so data and read_valid appear one cycle after oe.
// Backpressure: none; busy is high while the clear runs, and oe/wre are ignored then.
module neuron_param_dp_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 40,
  parameter int PEEK_ADDR = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              oe,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              wre,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              addr_err,
  output logic [DATA_W-1:0] peek_data
);

  // IDX_W indexes the storage array; CNT_W is wide enough to hold DEPTH itself.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // DEPTH may equal 2^ADDR_W, so range checks are done one bit wider than the address.
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_ok;
  logic              wr_ok;
  logic              bypass;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              err_now;

  assign rd_ok     = ({1'b0, read_address}  < DEPTH_EXT);
  assign wr_ok     = ({1'b0, write_address} < DEPTH_EXT);
  assign bypass    = wre && wr_ok && (read_address == write_address);
  assign peek_data = mem[PEEK_ADDR];

  // Next-state logic: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear address counter; holds at the last word instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state_q == CLEAR && clr_cnt != CLR_LAST) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Write-port arbitration: the clear sequence owns the port until READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt[IDX_W-1:0];
      end else if (wre && wr_ok) begin
        mem_we    = 1'b1;
        mem_waddr = write_address[IDX_W-1:0];
        mem_wdata = write_data;
      end
    end
  end

  // Storage array; contents are initialised by the clear sequence, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read word selection: out-of-range reads return zero, same-address writes bypass.
  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      if (bypass) begin
        rd_word = write_data;
      end else begin
        rd_word = mem[read_address[IDX_W-1:0]];
      end
    end
  end

  // One error pulse per cycle regardless of how many ports were out of range.
  assign err_now = (state_q == READY) && ((oe && !rd_ok) || (wre && !wr_ok));

  // Registered read result, valid strobe and address-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      addr_err <= err_now;
      if (state_q == READY && oe) begin
        read_data  <= rd_word;
        read_valid <= 1'b1;
      end else begin
        read_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_neuron_param_dp_ram.sv
module tb_neuron_param_dp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (8-bit data, 40 words).
  logic       a_rst = 1'b0;
  logic [7:0] a_raddr = '0;
  logic       a_oe = 1'b0;
  logic [7:0] a_waddr = '0;
  logic [7:0] a_wdata = '0;
  logic       a_wre = 1'b0;
  logic [7:0] a_rdata;
  logic       a_rvld;
  logic       a_busy;
  logic       a_err;
  logic [7:0] a_peek;

  // Wide instance (16-bit data, 256 words filling the whole address space).
  logic        b_rst = 1'b0;
  logic [7:0]  b_raddr = '0;
  logic        b_oe = 1'b0;
  logic [7:0]  b_waddr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_wre = 1'b0;
  logic [15:0] b_rdata;
  logic        b_rvld;
  logic        b_busy;
  logic        b_err;
  logic [15:0] b_peek;

  neuron_param_dp_ram u_a (
    .clk(clk), .rst(a_rst), .read_address(a_raddr), .oe(a_oe),
    .write_address(a_waddr), .write_data(a_wdata), .wre(a_wre),
    .read_data(a_rdata), .read_valid(a_rvld), .busy(a_busy),
    .addr_err(a_err), .peek_data(a_peek)
  );

  neuron_param_dp_ram #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .PEEK_ADDR(20)) u_b (
    .clk(clk), .rst(b_rst), .read_address(b_raddr), .oe(b_oe),
    .write_address(b_waddr), .write_data(b_wdata), .wre(b_wre),
    .read_data(b_rdata), .read_valid(b_rvld), .busy(b_busy),
    .addr_err(b_err), .peek_data(b_peek)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;

    // ---------------- Reset and initial clear (40 words) ----------------
    #2;
    a_rst = 1'b1;
    step();
    chk("rst_busy", {31'd0, a_busy}, 32'd1);
    chk("rst_rvld", {31'd0, a_rvld}, 32'd0);
    chk("rst_rdata", {24'd0, a_rdata}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    a_rst = 1'b0;
    n = 0;
    while (a_busy && n < 1000) begin
      step();
      n++;
    end
    chk("clear_len_40", n, 32'd40);
    chk("peek_after_clear", {24'd0, a_peek}, 32'd0);

    bad = 0;
    for (int i = 0; i < 40; i++) begin
      a_raddr = 8'(i);
      a_oe = 1'b1;
      step();
      if (a_rdata !== 8'h00 || a_rvld !== 1'b1) bad++;
    end
    a_oe = 1'b0;
    chk("all_words_zero", bad, 32'd0);

    // ---------------- Write 0xA5 to 3, read back ----------------
    a_waddr = 8'd3; a_wdata = 8'hA5; a_wre = 1'b1;
    step();
    a_wre = 1'b0;
    chk("write_no_rvld", {31'd0, a_rvld}, 32'd0);
    a_raddr = 8'd3; a_oe = 1'b1;
    step();
    a_oe = 1'b0;
    chk("rd3_data", {24'd0, a_rdata}, 32'hA5);
    chk("rd3_vld", {31'd0, a_rvld}, 32'd1);
    step();
    chk("rd3_vld_width1", {31'd0, a_rvld}, 32'd0);
    chk("rd3_data_hold", {24'd0, a_rdata}, 32'hA5);

    // ---------------- Write-first bypass at the peek address ----------------
    chk("peek_before_wr", {24'd0, a_peek}, 32'd0);
    a_waddr = 8'd20; a_raddr = 8'd20; a_wdata = 8'h3C; a_wre = 1'b1; a_oe = 1'b1;
    step();
    a_wre = 1'b0; a_oe = 1'b0;
    chk("bypass_data", {24'd0, a_rdata}, 32'h3C);
    chk("bypass_vld", {31'd0, a_rvld}, 32'd1);
    chk("peek_after_wr", {24'd0, a_peek}, 32'h3C);

    // ---------------- Out-of-range accesses ----------------
    a_waddr = 8'd40; a_wdata = 8'h77; a_wre = 1'b1;
    step();
    a_wre = 1'b0;
    chk("oob_wr_err", {31'd0, a_err}, 32'd1);
    chk("oob_wr_no_rvld", {31'd0, a_rvld}, 32'd0);
    step();
    chk("oob_wr_err_width1", {31'd0, a_err}, 32'd0);
    a_raddr = 8'd40; a_oe = 1'b1;
    step();
    a_oe = 1'b0;
    chk("oob_rd_data", {24'd0, a_rdata}, 32'd0);
    chk("oob_rd_vld", {31'd0, a_rvld}, 32'd1);
    chk("oob_rd_err", {31'd0, a_err}, 32'd1);
    // Aliased locations must be untouched by the rejected write.
    a_raddr = 8'd8; a_oe = 1'b1;
    step();
    chk("alias8_zero", {24'd0, a_rdata}, 32'd0);
    chk("inrange_no_err", {31'd0, a_err}, 32'd0);
    a_raddr = 8'd39;
    step();
    a_oe = 1'b0;
    chk("last_word_zero", {24'd0, a_rdata}, 32'd0);
    chk("peek_unchanged", {24'd0, a_peek}, 32'h3C);
    // Both ports out of range together produce a single pulse.
    a_waddr = 8'd50; a_raddr = 8'd60; a_wre = 1'b1; a_oe = 1'b1;
    step();
    a_wre = 1'b0; a_oe = 1'b0;
    chk("both_oob_err", {31'd0, a_err}, 32'd1);
    step();
    chk("both_oob_err_width1", {31'd0, a_err}, 32'd0);

    // ---------------- Reset mid-clear, user traffic ignored in CLEAR ----------------
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    a_waddr = 8'd3; a_raddr = 8'd3; a_wdata = 8'h11; a_wre = 1'b1; a_oe = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (a_rvld !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b1) bad++;
    end
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    n = 0;
    while (a_busy && n < 1000) begin
      step();
      n++;
      if (a_rvld !== 1'b0 && a_busy) bad++;
    end
    a_wre = 1'b0; a_oe = 1'b0;
    chk("clear_ignores_user", bad, 32'd0);
    chk("restart_len_40", n, 32'd40);
    chk("restart_peek_zero", {24'd0, a_peek}, 32'd0);
    a_raddr = 8'd3; a_oe = 1'b1;
    step();
    a_oe = 1'b0;
    chk("no_write_in_clear", {24'd0, a_rdata}, 32'd0);

    // ---------------- Wide instance: 16-bit, 256 words ----------------
    b_rst = 1'b1;
    step();
    chk("b_rst_busy", {31'd0, b_busy}, 32'd1);
    b_rst = 1'b0;
    n = 0;
    while (b_busy && n < 2000) begin
      step();
      n++;
    end
    chk("b_clear_len_256", n, 32'd256);
    chk("b_peek_zero", {16'd0, b_peek}, 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      b_raddr = 8'(i);
      b_oe = 1'b1;
      step();
      if (b_rdata !== 16'h0000 || b_rvld !== 1'b1) bad++;
    end
    b_oe = 1'b0;
    chk("b_all_words_zero", bad, 32'd0);
    b_waddr = 8'd255; b_wdata = 16'hBEEF; b_wre = 1'b1;
    step();
    b_wre = 1'b0;
    chk("b_wr_no_err", {31'd0, b_err}, 32'd0);
    b_raddr = 8'd255; b_oe = 1'b1;
    step();
    b_oe = 1'b0;
    chk("b_rd255_data", {16'd0, b_rdata}, 32'hBEEF);
    chk("b_rd255_vld", {31'd0, b_rvld}, 32'd1);
    step();
    chk("b_rd255_vld_width1", {31'd0, b_rvld}, 32'd0);
    b_raddr = 8'd0; b_oe = 1'b1;
    step();
    b_oe = 1'b0;
    chk("b_rd0_untouched", {16'd0, b_rdata}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/neuron_param_dp_ram.md
NEURON_PARAM_DP_RAM -- requirements
Module: neuron_param_dp_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 40, meaning number of words; DEPTH <= 2^ADDR_W.
REQ-004 The block SHALL have parameter PEEK_ADDR, default 20, meaning the word mirrored on peek_data; PEEK_ADDR < DEPTH.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 The block SHALL have port read_address, input, ADDR_W bits, the read port address.
REQ-008 The block SHALL have port oe, input, 1 bit, the read request strobe.
REQ-009 The block SHALL have port write_address, input, ADDR_W bits, the write port address.
REQ-010 The block SHALL have port write_data, input, DATA_W bits, the write port data.
REQ-011 The block SHALL have port wre, input, 1 bit, the write enable.
REQ-012 The block SHALL have port read_data, output, DATA_W bits, the registered read result.
REQ-013 The block SHALL have port read_valid, output, 1 bit, a one-cycle pulse qualifying read_data.
REQ-014 The block SHALL have port busy, output, 1 bit, high while the clear sequence runs.
REQ-015 The block SHALL have port addr_err, output, 1 bit, a one-cycle pulse on an out-of-range access.
REQ-016 The block SHALL have port peek_data, output, DATA_W bits, equal to mem[PEEK_ADDR] combinationally (debug).

Function
REQ-017 The FSM SHALL have two states: CLEAR and READY.
REQ-018 In CLEAR, the block SHALL write 0 to one word per cycle, addresses 0..DEPTH-1 ascending, then enter READY; CLEAR lasts exactly DEPTH cycles.
REQ-019 busy SHALL be 1 in CLEAR and 0 in READY.
REQ-020 In CLEAR, oe and wre SHALL be ignored: no user write, read_valid=0, addr_err=0.
REQ-021 In READY, with wre=1 and write_address < DEPTH, mem[write_address] SHALL be updated with write_data at the clock edge.
REQ-022 In READY, with oe=1 sampled at edge N, read_data SHALL present the word at edge N+1 with read_valid=1 for that one cycle (latency 1).
REQ-023 When oe=1, wre=1 and read_address == write_address (in range) in the same cycle, read_data SHALL return the new write_data (write-first bypass).
REQ-024 With oe=0, read_data SHALL hold its last value and read_valid SHALL be 0; the output is never tristated.
REQ-025 A write with write_address >= DEPTH SHALL leave the memory unchanged and pulse addr_err on the next cycle.
REQ-026 A read with read_address >= DEPTH SHALL return read_data=0 with read_valid=1 and pulse addr_err on the next cycle.
REQ-027 addr_err SHALL be a single pulse when both ports are out of range in the same cycle.
REQ-028 peek_data SHALL reflect a write to PEEK_ADDR from the cycle after the write edge, and SHALL read 0 after clear completes.
REQ-029 The clear counter SHALL be sized ceil(log2(DEPTH+1)) bits and SHALL not wrap past DEPTH-1.

Reset
REQ-030 rst=1 at an edge SHALL set read_data=0, read_valid=0 and addr_err=0, zero the clear counter and enter CLEAR; busy SHALL read 1 from the following cycle.
REQ-031 rst asserted mid-CLEAR or mid-READY SHALL restart the clear from address 0, with a full DEPTH cycles of busy after rst deasserts.
REQ-032 While rst=1, no user write SHALL occur.

Verification
REQ-033 Pulse rst for 1 cycle, then count busy cycles -> exactly 40; all 40 words read back 0; peek_data=0.
REQ-034 In READY, write 0xA5 to address 3, then read address 3 -> read_data=0xA5 one cycle after oe, read_valid pulse width 1.
REQ-035 Drive wre=1, oe=1, both addresses 20, data 0x3C in the same cycle -> next cycle read_data=0x3C, and peek_data=0x3C.
REQ-036 Write 0x77 to address 40, then read address 40 -> memory unchanged; addr_err pulses after each access; read returns 0 with read_valid=1.
REQ-037 Assert rst at clear cycle 15 -> busy stays high for 40 more cycles after rst drops; oe/wre during CLEAR produce no read_valid and no write.
REQ-038 Rerun REQ-033 and REQ-034 with DATA_W=16, DEPTH=256, ADDR_W=8 -> 256 busy cycles; 0xBEEF written to address 255 reads back intact.
